// File: rtl/if_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_if
// Description : Redirect/stall, instruction-memory and IF/ID bundle of the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_if #(
    parameter int CNT_W = 16
) ();
    logic             stall_i;
    logic             branch_taken_i;
    logic [31:0]      branch_target_i;
    logic             jump_i;
    logic [25:0]      jump_index_i;
    logic [31:0]      imem_addr_o;
    logic [31:0]      imem_data_i;
    logic [31:0]      pc_o;
    logic [31:0]      ifid_instr_o;
    logic [31:0]      ifid_pc_plus4_o;
    logic             ifid_valid_o;
    logic [CNT_W-1:0] fetch_count_o;

    // The fetch stage itself.
    modport master (
        input  stall_i, branch_taken_i, branch_target_i, jump_i, jump_index_i,
        input  imem_data_i,
        output imem_addr_o, pc_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o,
        output fetch_count_o
    );

    // Hazard/EX logic, instruction memory and decode.
    modport slave (
        output stall_i, branch_taken_i, branch_target_i, jump_i, jump_index_i,
        output imem_data_i,
        input  imem_addr_o, pc_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o,
        input  fetch_count_o
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Program counter, instruction-memory addressing and IF/ID
//               pipeline register with branch/jump redirect and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    if_fetch_if.master bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_plus4_q, pc_plus4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      w_pc_plus4;
    logic             w_redirect;
    logic             w_unused;

    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_redirect = bus.branch_taken_i | bus.jump_i;
    assign w_unused   = &{1'b0, bus.branch_target_i[1:0]};

    always_comb begin
        pc_d       = w_pc_plus4;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;

        // Branch is the older instruction, so it beats a same-cycle jump.
        if (bus.branch_taken_i) begin
            pc_d = {bus.branch_target_i[31:2], 2'b00};
        end else if (bus.jump_i) begin
            pc_d = {pc_plus4_q[31:28], bus.jump_index_i, 2'b00};
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end

        if (w_redirect) begin
            instr_d    = 32'd0;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (!bus.stall_i) begin
            instr_d    = bus.imem_data_i;
            pc_plus4_d = w_pc_plus4;
            valid_d    = 1'b1;
            if (cnt_q != c_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr_o     = pc_q;
    assign bus.pc_o            = pc_q;
    assign bus.ifid_instr_o    = instr_q;
    assign bus.ifid_pc_plus4_o = pc_plus4_q;
    assign bus.ifid_valid_o    = valid_q;
    assign bus.fetch_count_o   = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed and randomized bench for if_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_if #(.CNT_W(16)) bus_m ();
    if_fetch_if #(.CNT_W(16)) bus_w ();
    if_fetch_if #(.CNT_W(2))  bus_s ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u_main (.clk(clk), .rst(rst), .bus(bus_m));
    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(16)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));
    if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2))  u_sat  (.clk(clk), .rst(rst), .bus(bus_s));

    // Memory returns a word derived from its address.
    assign bus_m.imem_data_i = 32'h1000_0000 + bus_m.imem_addr_o;
    assign bus_w.imem_data_i = 32'h1000_0000 + bus_w.imem_addr_o;
    assign bus_s.imem_data_i = 32'h1000_0000 + bus_s.imem_addr_o;
    assign bus_w.stall_i = 1'b0;  assign bus_w.branch_taken_i = 1'b0;
    assign bus_w.jump_i  = 1'b0;  assign bus_w.branch_target_i = 32'd0;
    assign bus_w.jump_index_i = 26'd0;
    assign bus_s.stall_i = 1'b0;  assign bus_s.branch_taken_i = 1'b0;
    assign bus_s.jump_i  = 1'b0;  assign bus_s.branch_target_i = 32'd0;
    assign bus_s.jump_index_i = 26'd0;

    // Reference model of the main instance (architectural view of the stage).
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    int          m_cnt;

    task automatic model_step();
        logic [31:0] old_pp4;
        old_pp4 = m_pp4;
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0; m_cnt = 0;
        end else if (bus_m.branch_taken_i || bus_m.jump_i) begin
            if (bus_m.branch_taken_i) m_pc = bus_m.branch_target_i & 32'hFFFF_FFFC;
            else m_pc = {old_pp4[31:28], bus_m.jump_index_i, 2'b00};
            m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0;
        end else if (!bus_m.stall_i) begin
            m_instr = 32'h1000_0000 + m_pc;
            m_pp4   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_m.stall_i = 1'b0; bus_m.branch_taken_i = 1'b0; bus_m.jump_i = 1'b0;
        bus_m.branch_target_i = 32'd0; bus_m.jump_index_i = 26'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus_m.pc_o !== 32'd0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus_m.pc_o); end
        n_vec++; if (bus_m.ifid_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus_m.ifid_valid_o); end
        n_vec++; if (bus_m.ifid_instr_o !== 32'd0 || bus_m.ifid_pc_plus4_o !== 32'd0) begin
            n_err++; $display("FAIL reset_ifid got %h/%h want 0/0", bus_m.ifid_instr_o, bus_m.ifid_pc_plus4_o); end
        n_vec++; if (bus_m.fetch_count_o !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus_m.fetch_count_o); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus_m.pc_o !== 32'(4*i) || bus_m.imem_addr_o !== 32'(4*i)) begin
                n_err++; $display("FAIL run_pc[%0d] got %h/%h want %h", i, bus_m.pc_o, bus_m.imem_addr_o, 4*i); end
            if (i > 0) begin
                n_vec++; if (bus_m.ifid_instr_o !== 32'h1000_0000 + 32'(4*(i-1)) || bus_m.ifid_pc_plus4_o !== 32'(4*i)
                             || bus_m.ifid_valid_o !== 1'b1) begin
                    n_err++; $display("FAIL run_ifid[%0d] got %h/%h/%b want %h/%h/1", i, bus_m.ifid_instr_o,
                                      bus_m.ifid_pc_plus4_o, bus_m.ifid_valid_o, 32'h1000_0000 + 32'(4*(i-1)), 4*i); end
            end
            n_vec++; if (bus_m.fetch_count_o !== 16'(i)) begin
                n_err++; $display("FAIL run_count[%0d] got %0d want %0d", i, bus_m.fetch_count_o, i); end
            if (i < 4) tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick();
        bus_m.stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (bus_m.pc_o !== 32'd8 || bus_m.ifid_instr_o !== 32'h1000_0004 || bus_m.ifid_valid_o !== 1'b1
                         || bus_m.ifid_pc_plus4_o !== 32'd8 || bus_m.fetch_count_o !== 16'd2) begin
                n_err++; $display("FAIL stall_hold[%0d] got pc=%h instr=%h v=%b cnt=%0d want 8/10000004/1/2", i,
                                  bus_m.pc_o, bus_m.ifid_instr_o, bus_m.ifid_valid_o, bus_m.fetch_count_o); end
        end
        bus_m.stall_i = 1'b0;
        tick();
        n_vec++; if (bus_m.pc_o !== 32'd12 || bus_m.ifid_instr_o !== 32'h1000_0008 || bus_m.fetch_count_o !== 16'd3) begin
            n_err++; $display("FAIL stall_release got pc=%h instr=%h cnt=%0d want c/10000008/3",
                              bus_m.pc_o, bus_m.ifid_instr_o, bus_m.fetch_count_o); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) tick();
        bus_m.branch_taken_i = 1'b1; bus_m.branch_target_i = 32'h0000_0103;
        tick();
        idle_inputs();
        n_vec++; if (bus_m.pc_o !== 32'h100) begin n_err++; $display("FAIL branch_pc got %h want 100", bus_m.pc_o); end
        n_vec++; if (bus_m.ifid_valid_o !== 1'b0 || bus_m.ifid_instr_o !== 32'd0 || bus_m.fetch_count_o !== 16'd4) begin
            n_err++; $display("FAIL branch_flush got v=%b instr=%h cnt=%0d want 0/0/4",
                              bus_m.ifid_valid_o, bus_m.ifid_instr_o, bus_m.fetch_count_o); end
        tick();
        n_vec++; if (bus_m.ifid_instr_o !== 32'h1000_0100 || bus_m.ifid_pc_plus4_o !== 32'h104 || bus_m.ifid_valid_o !== 1'b1) begin
            n_err++; $display("FAIL branch_target_fetch got %h/%h/%b want 10000100/104/1",
                              bus_m.ifid_instr_o, bus_m.ifid_pc_plus4_o, bus_m.ifid_valid_o); end
    endtask

    task automatic test_jump(input bit only_jump);
        logic [31:0] exp_pc;
        do_reset();
        bus_m.branch_taken_i = 1'b1; bus_m.branch_target_i = 32'hA000_000C;
        tick();
        idle_inputs();
        tick();
        n_vec++; if (bus_m.ifid_pc_plus4_o !== 32'hA000_0010) begin
            n_err++; $display("FAIL jump_setup got %h want a0000010", bus_m.ifid_pc_plus4_o); end
        bus_m.jump_i = 1'b1; bus_m.jump_index_i = 26'h0000040;
        if (!only_jump) begin
            bus_m.branch_taken_i = 1'b1; bus_m.branch_target_i = 32'h0000_0203; bus_m.stall_i = 1'b1;
            exp_pc = 32'h0000_0200;
        end else begin
            exp_pc = 32'hA000_0100;
        end
        tick();
        idle_inputs();
        n_vec++; if (bus_m.pc_o !== exp_pc) begin
            n_err++; $display("FAIL jump_pc[%0d] got %h want %h", only_jump, bus_m.pc_o, exp_pc); end
        n_vec++; if (bus_m.ifid_valid_o !== 1'b0 || bus_m.ifid_instr_o !== 32'd0) begin
            n_err++; $display("FAIL jump_flush[%0d] got v=%b instr=%h want 0/0", only_jump, bus_m.ifid_valid_o, bus_m.ifid_instr_o); end
        tick();
        n_vec++; if (bus_m.ifid_instr_o !== 32'h1000_0000 + exp_pc || bus_m.pc_o !== exp_pc + 32'd4) begin
            n_err++; $display("FAIL jump_fetch[%0d] got instr=%h pc=%h want %h/%h", only_jump,
                              bus_m.ifid_instr_o, bus_m.pc_o, 32'h1000_0000 + exp_pc, exp_pc + 32'd4); end
    endtask

    task automatic test_wrap_sat();
        int exp_cnt;
        do_reset();
        n_vec++; if (bus_w.pc_o !== 32'hFFFF_FFF8 || bus_s.fetch_count_o !== 2'd0) begin
            n_err++; $display("FAIL wrap_reset got pc=%h cnt=%0d want fffffff8/0", bus_w.pc_o, bus_s.fetch_count_o); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                n_vec++; if (bus_w.pc_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc1 got %h want fffffffc", bus_w.pc_o); end
            end
            if (k == 2) begin
                n_vec++; if (bus_w.pc_o !== 32'd0 || bus_w.ifid_pc_plus4_o !== 32'd0 || bus_w.ifid_valid_o !== 1'b1) begin
                    n_err++; $display("FAIL wrap_pc2 got pc=%h pp4=%h v=%b want 0/0/1", bus_w.pc_o, bus_w.ifid_pc_plus4_o, bus_w.ifid_valid_o); end
            end
            exp_cnt = (k < 3) ? k : 3;
            n_vec++; if (bus_s.fetch_count_o !== 2'(exp_cnt)) begin
                n_err++; $display("FAIL sat_count[%0d] got %0d want %0d", k, bus_s.fetch_count_o, exp_cnt); end
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        tick(); tick();
        bus_m.stall_i = 1'b1; bus_m.branch_taken_i = 1'b1; bus_m.branch_target_i = 32'h0000_0300;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_vec++; if (bus_m.pc_o !== 32'd0 || bus_m.ifid_valid_o !== 1'b0 || bus_m.fetch_count_o !== 16'd0) begin
            n_err++; $display("FAIL rst_override got pc=%h v=%b cnt=%0d want 0/0/0", bus_m.pc_o, bus_m.ifid_valid_o, bus_m.fetch_count_o); end
        tick();
        n_vec++; if (bus_m.pc_o !== 32'd4) begin n_err++; $display("FAIL rst_override_next got %h want 4", bus_m.pc_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst                   = ($urandom_range(0, 49) == 0);
            bus_m.stall_i         = ($urandom_range(0, 3) == 0);
            bus_m.branch_taken_i  = ($urandom_range(0, 7) == 0);
            bus_m.jump_i          = ($urandom_range(0, 7) == 0);
            bus_m.branch_target_i = $urandom;
            bus_m.jump_index_i    = 26'($urandom);
            #1;
            n_vec++; if (bus_m.imem_addr_o !== m_pc) begin
                n_err++; $display("FAIL rnd_addr_comb[%0d] got %h want %h", i, bus_m.imem_addr_o, m_pc); end
            tick();
            n_vec++; if (bus_m.pc_o !== m_pc || bus_m.ifid_instr_o !== m_instr || bus_m.ifid_pc_plus4_o !== m_pp4
                         || bus_m.ifid_valid_o !== m_valid || bus_m.fetch_count_o !== 16'(m_cnt)) begin
                n_err++; $display("FAIL rnd_state[%0d] got pc=%h i=%h p=%h v=%b c=%0d want %h/%h/%h/%b/%0d", i,
                                  bus_m.pc_o, bus_m.ifid_instr_o, bus_m.ifid_pc_plus4_o, bus_m.ifid_valid_o,
                                  bus_m.fetch_count_o, m_pc, m_instr, m_pp4, m_valid, m_cnt); end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        m_pc = 32'd0; m_instr = 32'd0; m_pp4 = 32'd0; m_valid = 1'b0; m_cnt = 0;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_jump(1'b0);
        test_jump(1'b1);
        test_wrap_sat();
        test_reset_override();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end of PipelineCPU: owns the program counter, drives the instruction-memory address and captures fetched words into the IF/ID pipeline register.
- Consumes redirect (branch/jump) and stall requests from downstream hazard/EX logic.
- Replaces the external address feedback loop currently closed in the bench.
- Feeds the decode stage directly.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall_i  input  1  hold PC and IF/ID (load-use hazard)
- branch_taken_i  input  1  taken branch resolved this cycle
- branch_target_i  input  32  branch destination byte address
- jump_i  input  1  jump decoded in ID this cycle
- jump_index_i  input  26  J-type instr_index field
- imem_addr_o  output  32  instruction memory address, equals current PC
- imem_data_i  input  32  instruction word at imem_addr_o, combinational read
- pc_o  output  32  current PC
- ifid_instr_o  output  32  IF/ID instruction
- ifid_pc_plus4_o  output  32  IF/ID PC+4 of held instruction
- ifid_valid_o  output  1  IF/ID holds a real instruction
- fetch_count_o  output  CNT_W  instructions accepted into IF/ID

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-stall or mid-redirect):
  - pc=RESET_PC
  - ifid_instr_o=0, ifid_pc_plus4_o=0, ifid_valid_o=0
  - fetch_count_o=0
- imem_addr_o = pc_o, combinational.
- pc_plus4 = pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Next-PC priority, highest first:
  1. rst
  2. branch_taken_i: pc <= {branch_target_i[31:2],2'b00}
  3. jump_i: pc <= {ifid_pc_plus4_o[31:28], jump_index_i, 2'b00}
  4. stall_i: pc holds
  5. otherwise: pc <= pc_plus4
- IF/ID update, same priority:
  - Redirect (branch or jump): flush. ifid_instr_o <= 0 (NOP), ifid_valid_o <= 0, ifid_pc_plus4_o <= 0. Redirect overrides a simultaneous stall_i.
  - stall_i only: all IF/ID fields hold.
  - Normal: ifid_instr_o <= imem_data_i, ifid_pc_plus4_o <= pc_plus4, ifid_valid_o <= 1.
- Latency:
  - Word at PC appears on ifid_instr_o one cycle after PC is presented.
  - Redirect target appears on pc_o the cycle after the redirect. Its word enters IF/ID one cycle later.
  - Redirect penalty is one bubble.
- Simultaneous branch_taken_i and jump_i: branch wins (older instruction).
- fetch_count_o increments by 1 on each normal (non-stall, non-redirect) IF/ID load. Saturates at all-ones, no wrap.
- No combinational path from stall_i/branch_taken_i/jump_i to imem_addr_o; they affect only registered state.
- ifid outputs are purely registered.

Test Plan:
- Reset then 5 free-running cycles, imem returns 32'h1000_0000+addr:
  - pc_o goes 0,4,8,12,16
  - ifid_instr_o lags one cycle (first valid 32'h1000_0000, ifid_pc_plus4_o=4)
  - fetch_count_o=4 after cycle 5
- At pc=8, assert stall_i for 2 cycles:
  - pc_o stays 8
  - IF/ID holds instr from pc=4, valid=1
  - count unchanged
  - resumes at 12 after release
- At pc=16, branch_taken_i=1 with target 32'h0000_0103:
  - next pc_o=32'h100 (low bits masked)
  - IF/ID flushed: valid=0, instr=0
  - following cycle IF/ID holds word from 0x100
- Jump with ifid_pc_plus4_o=32'hA000_0010 and jump_index_i=26'h0000040, branch_taken_i and stall_i both asserted same cycle:
  - branch target taken, jump ignored, flush occurs despite stall
  - repeat with only jump_i: pc_o=32'hA000_0100
- Wrap and saturation:
  - RESET_PC=32'hFFFF_FFF8, run 3 cycles: pc sequence FFFF_FFF8, FFFF_FFFC, 0
  - CNT_W=2, run 6 normal loads: fetch_count_o sticks at 3
- Assert rst for one cycle during stall with pending branch:
  - next edge gives pc=RESET_PC, ifid_valid_o=0, count=0
  - branch ignored
